// File: rtl/hgcal_input_deserializer_if.sv
// Stream bundle between the sample source, the input deserializer and the
// layer-0 neurons.
//   master : drives samples (s_valid/s_data/s_last) and consumes frames (m_ready)
//   slave  : the deserializer; returns s_ready and presents m_valid/m_vec plus
//            the framing status (frame_err pulse, saturating drop_cnt)
interface hgcal_input_deserializer_if #(
  parameter int IN_BW      = 8,
  parameter int BW         = 2,
  parameter int N_PER_BEAT = 4,
  parameter int N_BEATS    = 12,
  parameter int CNT_W      = 16
);
  localparam int VEC_W = N_PER_BEAT * N_BEATS * BW;

  logic                        s_valid;
  logic                        s_ready;
  logic [N_PER_BEAT*IN_BW-1:0] s_data;
  logic                        s_last;
  logic                        m_valid;
  logic                        m_ready;
  logic [VEC_W-1:0]            m_vec;
  logic                        frame_err;
  logic [CNT_W-1:0]            drop_cnt;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_vec, frame_err, drop_cnt
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_vec, frame_err, drop_cnt
  );
endinterface

// File: rtl/hgcal_input_deserializer.sv
// Input deserializer for the HGCAL autoencoder LUT network. Requantizes raw
// unsigned samples (shift then saturate to BW bits), assembles N_BEATS beats
// of N_PER_BEAT samples into one packed feature vector and holds it for the
// layer-0 neurons until m_ready consumes it. Badly framed input (s_last early
// or missing) is discarded with a one-cycle frame_err and a saturating count.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of hgcal_input_deserializer_if (sample stream in,
//            packed frame out, frame_err, drop_cnt)
//
// state      | meaning
// ST_COLLECT | accepting beats, writing features at beat_cnt
// ST_FULL    | frame complete, m_vec held until m_valid & m_ready
module hgcal_input_deserializer #(
  parameter int IN_BW      = 8,
  parameter int SHIFT      = 4,
  parameter int BW         = 2,
  parameter int N_PER_BEAT = 4,
  parameter int N_BEATS    = 12,
  parameter int CNT_W      = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  hgcal_input_deserializer_if.slave bus
);
  localparam int BEAT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int Q_W      = IN_BW - SHIFT;
  localparam int FEAT_MAX = (1 << BW) - 1;
  localparam int GRP_W    = N_PER_BEAT * BW;
  localparam int VEC_W    = N_PER_BEAT * N_BEATS * BW;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;

  logic [0:0]        r_state;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_s_ready;
  logic              r_frame_err;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [VEC_W-1:0]  r_vec;

  logic [GRP_W-1:0]  w_feat;
  logic              w_accept;
  logic              w_at_last;
  logic              w_err;
  logic              w_done;
  logic              w_handoff;

  // Taking bits [SHIFT +: Q_W] of each sample is the right shift; anything
  // above the BW-bit range clamps to all ones.
  always_comb begin
    w_feat = '0;
    for (int i = 0; i < N_PER_BEAT; i++) begin
      if (bus.s_data[i*IN_BW+SHIFT +: Q_W] > Q_W'(FEAT_MAX))
        w_feat[i*BW +: BW] = BW'(FEAT_MAX);
      else
        w_feat[i*BW +: BW] = bus.s_data[i*IN_BW+SHIFT +: BW];
    end
  end

  // s_ready is only ever high in ST_COLLECT, so it alone qualifies acceptance.
  assign w_accept  = bus.s_valid & r_s_ready;
  assign w_at_last = (r_beat_cnt == LAST_BEAT);
  // Error whenever s_last disagrees with the beat position: early s_last
  // (short frame) or no s_last on the final beat (long frame).
  assign w_err     = w_accept & (bus.s_last ^ w_at_last);
  assign w_done    = w_accept & bus.s_last & w_at_last;
  assign w_handoff = (r_state == ST_FULL) & bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_COLLECT;
      r_beat_cnt  <= '0;
      r_s_ready   <= 1'b0;
      r_frame_err <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_frame_err <= w_err;
      if (w_err && (r_drop_cnt != {CNT_W{1'b1}}))
        r_drop_cnt <= r_drop_cnt + 1'b1;

      case (r_state)
        ST_COLLECT: begin
          r_s_ready <= ~w_done;
          if (w_accept) begin
            if (w_done) begin
              r_state    <= ST_FULL;
              r_beat_cnt <= '0;
            end else if (w_err) begin
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (w_handoff) begin
            r_state   <= ST_COLLECT;
            r_s_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_COLLECT;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  // Feature storage; writes only on accepted beats, so the vector cannot
  // move while the frame is held in ST_FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
    end else if (w_accept) begin
      for (int b = 0; b < N_BEATS; b++) begin
        if (r_beat_cnt == BEAT_W'(b))
          r_vec[b*GRP_W +: GRP_W] <= w_feat;
      end
    end
  end

  assign bus.s_ready   = r_s_ready;
  assign bus.m_valid   = (r_state == ST_FULL);
  assign bus.m_vec     = r_vec;
  assign bus.frame_err = r_frame_err;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule
